// File: rtl/mef_rega_zonas_pkg.sv
// Shared types for the multi-zone irrigation controller:
// FSM states, per-zone valve modes and the request/sensor decoder.
package mef_rega_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
    typedef enum logic [1:0] {NONE, ASP, GOT, CONF} mode_t;

    function automatic mode_t decode(
        input logic rega,
        input logic vs,
        input logic bs
    );
        mode_t m;
        if (!rega || (!vs && !bs))
            m = NONE;
        else if (vs && bs)
            m = CONF;
        else if (bs)
            m = ASP;
        else
            m = GOT;
        return m;
    endfunction

endpackage

// File: rtl/mef_rega_zonas_if.sv
// Zone request/sensor inputs and valve/status outputs of the
// multi-zone irrigation controller.
interface mef_rega_zonas_if #(
    parameter int N_ZONES = 4
);
    localparam int ZW = $clog2(N_ZONES);

    logic               en;
    logic [N_ZONES-1:0] rega;
    logic [N_ZONES-1:0] vs;
    logic [N_ZONES-1:0] bs;
    logic [N_ZONES-1:0] asp;
    logic [N_ZONES-1:0] got;
    logic [N_ZONES-1:0] fault;
    logic               busy;
    logic [ZW-1:0]      zone_idx;

    modport master (
        output en, rega, vs, bs,
        input  asp, got, fault, busy, zone_idx
    );

    modport slave (
        input  en, rega, vs, bs,
        output asp, got, fault, busy, zone_idx
    );

endinterface

// File: rtl/mef_rega_zonas_rr_arbiter.sv
// Round-robin zone picker: first eligible zone strictly after
// i_ptr, wrapping, so the last-served zone has lowest priority.
module rr_arbiter_zonas #(
    parameter int N_ZONES = 4
) (
    input  logic [N_ZONES-1:0]         i_elig,
    input  logic [$clog2(N_ZONES)-1:0] i_ptr,
    output logic [$clog2(N_ZONES)-1:0] o_grant,
    output logic                       o_valid
);
    localparam int ZW = $clog2(N_ZONES);

    logic [ZW-1:0] w_j;

    // Scan from farthest to nearest so the nearest hit is written last.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_j     = '0;
        for (int k = N_ZONES; k >= 1; k--) begin
            w_j = ZW'((int'(i_ptr) + k) % N_ZONES);
            if (i_elig[w_j]) begin
                o_grant = w_j;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mef_rega_zonas.sv
// Multi-zone irrigation controller: per-zone mode decode and a
// shared-pump FSM with round-robin, min-on, run-slot and dead time.
module mef_rega_zonas #(
    parameter int N_ZONES     = 4,
    parameter int CNT_W       = 16,
    parameter int RUN_CYCLES  = 1000,
    parameter int MIN_ON      = 16,
    parameter int DEAD_CYCLES = 4
) (
    input logic             clk,
    input logic             reset,
    mef_rega_zonas_if.slave bus
);
    import mef_rega_pkg::*;

    localparam int ZW = $clog2(N_ZONES);
    localparam logic [CNT_W-1:0] MIN_LIM  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] RUN_LIM  = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_CYCLES - 1);

    if (N_ZONES < 2 || MIN_ON < 1 || DEAD_CYCLES < 1 ||
        RUN_CYCLES < MIN_ON ||
        longint'(RUN_CYCLES) > (longint'(1) << CNT_W) ||
        longint'(DEAD_CYCLES) > (longint'(1) << CNT_W)) begin : g_param_err
        $error("mef_rega_zonas: parameters out of range");
    end

    mode_t              w_mode [N_ZONES];
    logic [N_ZONES-1:0] w_elig;
    logic [N_ZONES-1:0] w_conf;
    logic [ZW-1:0]      w_grant;
    logic               w_valid;
    mode_t              w_cur_mode;
    mode_t              w_new_mode;
    logic [N_ZONES-1:0] w_cur_oh;
    logic [N_ZONES-1:0] w_go_oh;
    logic               w_stop;
    logic               w_go;

    state_t             r_state;
    logic [ZW-1:0]      r_cur;
    mode_t              r_mode_q;
    logic [ZW-1:0]      r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_ZONES-1:0] r_asp;
    logic [N_ZONES-1:0] r_got;
    logic [N_ZONES-1:0] r_fault;
    logic               r_busy;
    logic [ZW-1:0]      r_zone;

    always_comb begin
        for (int i = 0; i < N_ZONES; i++) begin
            w_mode[i] = decode(bus.rega[i], bus.vs[i], bus.bs[i]);
            w_elig[i] = (w_mode[i] == ASP) || (w_mode[i] == GOT);
            w_conf[i] = (w_mode[i] == CONF);
        end
    end

    rr_arbiter_zonas #(
        .N_ZONES (N_ZONES)
    ) u_arb (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    assign w_cur_mode = w_mode[r_cur];
    assign w_new_mode = w_mode[w_grant];
    assign w_cur_oh   = N_ZONES'(1) << r_cur;
    assign w_go_oh    = N_ZONES'(1) << w_grant;

    // Exit priority: shutdown/conflict, then mode change, then pre-emption.
    assign w_stop = !bus.en || (w_cur_mode == CONF) ||
                    ((w_cur_mode != r_mode_q) && (r_cnt >= MIN_LIM)) ||
                    ((r_cnt >= RUN_LIM) && |(w_elig & ~w_cur_oh));

    assign w_go = bus.en && w_valid &&
                  ((r_state == IDLE) ||
                   ((r_state == DEAD) && (r_cnt >= DEAD_LIM)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cur    <= '0;
            r_mode_q <= NONE;
            r_ptr    <= ZW'(N_ZONES - 1);
            r_cnt    <= '0;
            r_asp    <= '0;
            r_got    <= '0;
            r_fault  <= '0;
            r_busy   <= 1'b0;
            r_zone   <= '0;
        end else begin
            r_fault <= w_conf;
            if (w_go) begin
                r_state  <= RUN;
                r_cur    <= w_grant;
                r_ptr    <= w_grant;
                r_mode_q <= w_new_mode;
                r_cnt    <= '0;
                r_asp    <= (w_new_mode == ASP) ? w_go_oh : '0;
                r_got    <= (w_new_mode == GOT) ? w_go_oh : '0;
                r_busy   <= 1'b1;
                r_zone   <= w_grant;
            end else begin
                unique case (r_state)
                    RUN: begin
                        if (w_stop) begin
                            r_state <= DEAD;
                            r_cnt   <= '0;
                            r_asp   <= '0;
                            r_got   <= '0;
                            r_busy  <= 1'b0;
                        end else if (r_cnt != '1) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    DEAD: begin
                        if (r_cnt >= DEAD_LIM) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.asp      = r_asp;
    assign bus.got      = r_got;
    assign bus.fault    = r_fault;
    assign bus.busy     = r_busy;
    assign bus.zone_idx = r_zone;

endmodule

// File: tb/tb_mef_rega_zonas.sv
// Directed vector bench for mef_rega_zonas with four zones,
// run slot 8, min-on 3 and dead time 2.
module tb_mef_rega_zonas;

    typedef struct {
        logic       en;
        logic [3:0] rega;
        logic [3:0] vs;
        logic [3:0] bs;
        int         reps;
        logic [3:0] asp;
        logic [3:0] got;
        logic [3:0] flt;
        logic       busy;
        logic [1:0] zone;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    mef_rega_zonas_if #(.N_ZONES(4)) bus();

    mef_rega_zonas #(
        .N_ZONES     (4),
        .CNT_W       (16),
        .RUN_CYCLES  (8),
        .MIN_ON      (3),
        .DEAD_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    function automatic vec_t mk(
        input logic en, input logic [3:0] rega, input logic [3:0] vs,
        input logic [3:0] bs, input int reps, input logic [3:0] asp,
        input logic [3:0] got, input logic [3:0] flt, input logic busy,
        input logic [1:0] zone
    );
        vec_t v;
        v.en = en; v.rega = rega; v.vs = vs; v.bs = bs; v.reps = reps;
        v.asp = asp; v.got = got; v.flt = flt; v.busy = busy; v.zone = zone;
        return v;
    endfunction

    function automatic logic [14:0] outs();
        return {bus.asp, bus.got, bus.fault, bus.busy, bus.zone_idx};
    endfunction

    task automatic chk(input string name, input logic [14:0] act,
                       input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: {asp,got,fault,busy,zone} got %b expected %b",
                     name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] rega,
                         input logic [3:0] vs, input logic [3:0] bs);
        bus.en = en; bus.rega = rega; bus.vs = vs; bus.bs = bs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // single-zone sprinkler grant, held past the run slot
        tbl.push_back(mk(1, 4'b0010, 4'b0000, 4'b0010, 12, 4'b0010, 4'b0, 4'b0, 1, 2'd1));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0, 4'b0, 4'b0, 0, 2'd1));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 3, 4'b0, 4'b0, 4'b0, 0, 2'd1));
        // request dropped at cnt=0: min-on hold then dead time
        tbl.push_back(mk(1, 4'b0010, 4'b0000, 4'b0010, 1, 4'b0010, 4'b0, 4'b0, 1, 2'd1));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 2, 4'b0010, 4'b0, 4'b0, 1, 2'd1));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 3, 4'b0, 4'b0, 4'b0, 0, 2'd1));
        // conflict on the running zone
        tbl.push_back(mk(1, 4'b0001, 4'b0000, 4'b0001, 3, 4'b0001, 4'b0, 4'b0, 1, 2'd0));
        tbl.push_back(mk(1, 4'b0001, 4'b0001, 4'b0001, 1, 4'b0, 4'b0, 4'b0001, 0, 2'd0));
        tbl.push_back(mk(1, 4'b0001, 4'b0001, 4'b0001, 4, 4'b0, 4'b0, 4'b0001, 0, 2'd0));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0, 4'b0, 4'b0, 0, 2'd0));
        // enable dropped at cnt=1
        tbl.push_back(mk(1, 4'b1000, 4'b1000, 4'b0000, 2, 4'b0, 4'b1000, 4'b0, 1, 2'd3));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 4'b0000, 1, 4'b0, 4'b0, 4'b0, 0, 2'd3));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 4'b0000, 4, 4'b0, 4'b0, 4'b0, 0, 2'd3));
        // sprinkler to drip switch on the same zone
        tbl.push_back(mk(1, 4'b0100, 4'b0000, 4'b0100, 1, 4'b0100, 4'b0, 4'b0, 1, 2'd2));
        tbl.push_back(mk(1, 4'b0100, 4'b0100, 4'b0000, 2, 4'b0100, 4'b0, 4'b0, 1, 2'd2));
        tbl.push_back(mk(1, 4'b0100, 4'b0100, 4'b0000, 2, 4'b0, 4'b0, 4'b0, 0, 2'd2));
        tbl.push_back(mk(1, 4'b0100, 4'b0100, 4'b0000, 1, 4'b0, 4'b0100, 4'b0, 1, 2'd2));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 2, 4'b0, 4'b0100, 4'b0, 1, 2'd2));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 3, 4'b0, 4'b0, 4'b0, 0, 2'd2));

        drive(0, 4'b0, 4'b0, 4'b0);
        #1;
        chk("reset_state", outs(), 15'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", outs(), 15'b0);

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].rega, tbl[i].vs, tbl[i].bs);
            for (int r = 0; r < tbl[i].reps; r++) begin
                tick();
                chk($sformatf("vec%0d_rep%0d", i, r), outs(),
                    {tbl[i].asp, tbl[i].got, tbl[i].flt, tbl[i].busy, tbl[i].zone});
            end
        end

        // zones 0 and 2 compete: alternating 8-cycle slots, 2 off between
        drive(1, 4'b0101, 4'b0101, 4'b0000);
        for (int g = 0; g < 4; g++) begin
            logic [1:0] z;
            logic [3:0] oh;
            z  = (g % 2 == 0) ? 2'd0 : 2'd2;
            oh = 4'b0001 << z;
            for (int k = 0; k < 8; k++) begin
                tick();
                chk($sformatf("rr_g%0d_on%0d", g, k), outs(),
                    {4'b0, oh, 4'b0, 1'b1, z});
            end
            for (int k = 0; k < 2; k++) begin
                tick();
                chk($sformatf("rr_g%0d_off%0d", g, k), outs(),
                    {4'b0, 4'b0, 4'b0, 1'b0, z});
            end
        end
        drive(1, 4'b0, 4'b0, 4'b0);
        tick();
        chk("rr_to_idle", outs(), {12'b0, 1'b0, 2'd2});

        // async reset mid-run, then arbitration restarts at zone 0
        drive(1, 4'b0001, 4'b0000, 4'b0001);
        tick();
        chk("pre_reset_run", outs(), {4'b0001, 4'b0, 4'b0, 1'b1, 2'd0});
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_now", outs(), 15'b0);
        @(posedge clk);
        #1;
        chk("reset_held", outs(), 15'b0);
        rst_n = 1'b1;
        drive(1, 4'b0011, 4'b0000, 4'b0011);
        tick();
        chk("post_reset_zone0", outs(), {4'b0001, 4'b0, 4'b0, 1'b1, 2'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
